dual_switch_debounce: RTL and testbench
=======================================

Name: dual_switch_debounce

Overview:
- Front-end conditioning stage for the dual-switch XOR datapath.
- Takes two raw, asynchronous, bouncing board switch inputs and produces clean levels for the downstream XOR stage's a/b inputs, plus single-cycle edge pulses and an accepted-edge event counter.
- Per channel: a multi-flop synchronizer, then a 4-state debounce FSM with a stability counter.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth per channel; legal range is 2 or more.
- DEBOUNCE_CYCLES, 20000: number of consecutive identical synchronized samples required to accept a new level; legal range is 2 or more. The bench uses 4.
- CNT_W, 8: width of the accepted-edge event counter.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- sw_raw, input, 2: raw switch pins. Bit 0 is channel a, bit 1 is channel b. Asynchronous to clk.
- sw_level, output, 2: debounced levels; bit 0 feeds downstream a, bit 1 feeds downstream b.
- sw_rise, output, 2: one-cycle pulse when the channel's sw_level goes 0->1.
- sw_fall, output, 2: one-cycle pulse when the channel's sw_level goes 1->0.
- evt_cnt, output, CNT_W: running count of accepted edges on both channels.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - sync flops = 0, FSMs in ST_LO, stability counters = 0.
  - sw_level = 0, sw_rise = 0, sw_fall = 0, evt_cnt = 0.
  - Deassertion is taken on a clk edge. Switches held high through reset are accepted as rises after normal latency.
- Synchronizer: SYNC_STAGES-deep flop chain per channel; sw_s[i] is the last flop. No combinational path from sw_raw to any output.
- Per-channel FSM states: ST_LO, CHK_HI, ST_HI, CHK_LO. Counter cnt is wide enough to hold DEBOUNCE_CYCLES.
  - ST_LO: if sw_s=1, go to CHK_HI with cnt=1; else stay with cnt=0.
  - CHK_HI, sw_s=1, cnt<DEBOUNCE_CYCLES-1: cnt+1, stay.
  - CHK_HI, sw_s=1, cnt=DEBOUNCE_CYCLES-1: go to ST_HI; sw_level=1; sw_rise=1 for exactly this one cycle; cnt=0.
  - CHK_HI, sw_s=0: back to ST_LO, cnt=0, no pulse (glitch rejected).
  - ST_HI and CHK_LO: mirror images of ST_LO and CHK_HI with polarity swapped; acceptance produces sw_fall.
- Latency:
  - Counting as edge 1 the first clk edge at which sw_raw is sampled at the new value, and provided it stays stable, sw_level changes on edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives edge 6.
  - The pulse is registered and coincides with the sw_level change.
- Pulses:
  - sw_rise and sw_fall are never both high on the same channel.
  - At most one pulse per channel per accepted transition.
- evt_cnt:
  - Increments by the number of channels pulsing (rise or fall) on that cycle: 0, 1 or 2.
  - Simultaneous acceptance on both channels adds 2 in one cycle.
  - Arithmetic is modulo 2^CNT_W and wraps silently, e.g. 255+1=0 and 255+2=1 for CNT_W=8.
- Bounce shorter than DEBOUNCE_CYCLES consecutive samples never changes sw_level. Any opposite sample restarts the check from zero.
- Channels are fully independent apart from sharing evt_cnt.
- Reset mid-check: the FSM returns to ST_LO immediately and the partial count is discarded. No pulse is emitted on reset or on reset release.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8):
- Reset release, then sw_raw=00 held for 20 cycles -> sw_level=00, no pulses, evt_cnt=0.
- sw_raw[0] 0->1 sampled at edge 1 and held -> sw_level[0]=1 and sw_rise[0]=1 at edge 6 only; evt_cnt=1; sw_level[1] stays 0.
- sw_raw[1] toggles 1,0,1,1,0 (one cycle each, never 4 stable samples) -> sw_level[1] stays 0, no pulses, evt_cnt unchanged.
- Both channels raised at the same edge -> both sw_rise bits pulse together at edge 6; evt_cnt increases by 2 in one cycle.
- Preload evt_cnt to 254 via 254 accepted edges, then a simultaneous double fall -> evt_cnt wraps to 0 and the sw_fall bits pulse together.
- rst_n asserted mid-CHK_HI (cnt=2), released, raw input still high -> outputs 0 during reset, no pulse on release; rise accepted 6 edges after the first post-reset sample.

Source files
------------

// File: rtl/dual_switch_debounce.sv
// Two-channel switch conditioner: a synchronizer chain and a debounce FSM per channel,
// with registered level/edge outputs and a shared count of accepted edges.
module dual_switch_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sw_raw,
  output logic [1:0]       sw_level,
  output logic [1:0]       sw_rise,
  output logic [1:0]       sw_fall,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [1:0] accept;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    state_t                 st_q;
    logic [CW-1:0]          cnt_q;
    logic                   lvl_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw[i]};
      end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    // True on the cycle the FSM commits a new level; feeds the shared event counter.
    assign accept[i] = (cnt_q == CNT_LAST) &&
                       (((st_q == CHK_HI) && sw_s) || ((st_q == CHK_LO) && !sw_s));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= ST_LO;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (st_q)
          ST_LO: begin
            if (sw_s) begin
              st_q  <= CHK_HI;
              cnt_q <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          CHK_HI: begin
            if (!sw_s) begin
              st_q  <= ST_LO;
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              st_q   <= ST_HI;
              cnt_q  <= '0;
              lvl_q  <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_HI: begin
            if (!sw_s) begin
              st_q  <= CHK_LO;
              cnt_q <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          CHK_LO: begin
            if (sw_s) begin
              st_q  <= ST_HI;
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              st_q   <= ST_LO;
              cnt_q  <= '0;
              lvl_q  <= 1'b0;
              fall_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            st_q  <= ST_LO;
            cnt_q <= '0;
          end
        endcase
      end
    end

    assign sw_level[i] = lvl_q;
    assign sw_rise[i]  = rise_q;
    assign sw_fall[i]  = fall_q;
  end

  // Both channels may commit on the same edge, so the step is 0, 1 or 2 and wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else begin
      evt_cnt <= evt_cnt + CNT_W'(accept[0]) + CNT_W'(accept[1]);
    end
  end

endmodule

// File: tb/tb_dual_switch_debounce.sv
// Bench for dual_switch_debounce: directed test-plan steps followed by random switch
// activity, scored every cycle against a sliding-window reference model.
module tb_dual_switch_debounce;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CNT_W = 8;
  localparam int W     = CNT_W + 6;

  logic             clk;
  logic             rst_n;
  logic [1:0]       sw_raw;
  logic [1:0]       sw_level;
  logic [1:0]       sw_rise;
  logic [1:0]       sw_fall;
  logic [CNT_W-1:0] evt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dual_switch_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_level(sw_level),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .evt_cnt (evt_cnt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] word(input logic [CNT_W-1:0] evt, input logic [1:0] fall,
                                        input logic [1:0] rise, input logic [1:0] lvl);
    return {evt, fall, rise, lvl};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {evt_cnt, sw_fall, sw_rise, sw_level};
  endfunction

  // Reference model: the debouncer sees the raw pin SYNC edges late, and a channel
  // flips on the edge where its last DEB seen samples all disagree with its level.
  logic [1:0]       pipe [$];
  logic [DEB-1:0]   win [2];
  logic [1:0]       m_level;
  logic [CNT_W-1:0] m_evt;
  logic [W-1:0]     exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    logic [1:0]     seen;
    logic [1:0]     m_rise;
    logic [1:0]     m_fall;
    logic [DEB-1:0] opp;
    if (!rst_n) begin
      pipe.delete();
      for (int k = 0; k < SYNC; k++) pipe.push_back(2'b00);
      win[0]  = '0;
      win[1]  = '0;
      m_level = 2'b00;
      m_evt   = '0;
      exp_q.delete();
    end else begin
      pipe.push_back(sw_raw);
      seen   = pipe.pop_front();
      m_rise = 2'b00;
      m_fall = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        win[ch] = {win[ch][DEB-2:0], seen[ch]};
        opp = m_level[ch] ? {DEB{1'b0}} : {DEB{1'b1}};
        if (win[ch] == opp) begin
          if (m_level[ch]) m_fall[ch] = 1'b1;
          else             m_rise[ch] = 1'b1;
          m_level[ch] = ~m_level[ch];
          m_evt = m_evt + 1'b1;
        end
      end
      exp_q.push_back(word(m_evt, m_fall, m_rise, m_level));
    end
  end

  // Scoreboard: one comparison per cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      n_checks++;
      assert (dut_word() === '0) else begin
        n_errors++;
        $error("FAIL sb_reset observed=%h expected=%h", dut_word(), {W{1'b0}});
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      assert (dut_word() === e) else begin
        n_errors++;
        $error("FAIL sb_cycle observed=%h expected=%h", dut_word(), e);
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [1:0] raw, input int n);
    @(negedge clk);
    sw_raw = raw;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] exp);
    n_checks++;
    assert (dut_word() === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, dut_word(), exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", word(8'd0, 2'b00, 2'b00, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    drive(2'b00, 20);
    chk("idle", word(8'd0, 2'b00, 2'b00, 2'b00));

    // Single rise on channel a: accepted on edge 6 only
    drive(2'b01, 5);
    chk("rise_a_e5", word(8'd0, 2'b00, 2'b00, 2'b00));
    drive(2'b01, 1);
    chk("rise_a_e6", word(8'd1, 2'b00, 2'b01, 2'b01));
    drive(2'b01, 1);
    chk("rise_a_e7", word(8'd1, 2'b00, 2'b00, 2'b01));

    // Channel b bounces 1,0,1,1,0 and must be rejected
    drive(2'b11, 1);
    drive(2'b01, 1);
    drive(2'b11, 1);
    drive(2'b11, 1);
    drive(2'b01, 1);
    drive(2'b01, 8);
    chk("bounce_b", word(8'd1, 2'b00, 2'b00, 2'b01));

    // Channel a falls, then both rise together
    drive(2'b00, 8);
    chk("fall_a", word(8'd2, 2'b00, 2'b00, 2'b00));
    drive(2'b11, 5);
    chk("dual_rise_e5", word(8'd2, 2'b00, 2'b00, 2'b00));
    drive(2'b11, 1);
    chk("dual_rise_e6", word(8'd4, 2'b00, 2'b11, 2'b11));

    // Preload the counter to 254, then a double fall wraps it to 0
    for (int k = 0; k < 62; k++) begin
      drive(2'b00, 7);
      drive(2'b11, 7);
    end
    drive(2'b10, 7);
    drive(2'b11, 7);
    chk("preload_254", word(8'd254, 2'b00, 2'b00, 2'b11));
    drive(2'b00, 5);
    chk("wrap_e5", word(8'd254, 2'b00, 2'b00, 2'b11));
    drive(2'b00, 1);
    chk("wrap_e6", word(8'd0, 2'b11, 2'b00, 2'b00));

    // Reset in the middle of a high check, inputs held high through reset
    drive(2'b10, 7);
    chk("pre_rst_b", word(8'd1, 2'b00, 2'b00, 2'b10));
    drive(2'b11, 4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", word(8'd0, 2'b00, 2'b00, 2'b00));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", word(8'd0, 2'b00, 2'b00, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_e5", word(8'd0, 2'b00, 2'b00, 2'b00));
    @(posedge clk);
    #1;
    chk("post_rst_e6", word(8'd2, 2'b00, 2'b11, 2'b11));

    // Random switch activity with mixed hold lengths, scored by the model
    for (int k = 0; k < 150; k++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(1, 8));
    end
    drive(sw_raw, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
